// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file rd port.
// Also keeps a busy scoreboard of destination registers with pending writes.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32,
    parameter int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*5-1:0]      i_req_rd_index,
    input  logic [N_REQ*XLEN-1:0]   i_req_rd_data,
    input  logic                    i_issue_valid,
    input  logic [4:0]              i_issue_rd_index,
    output logic                    o_rd_write_enable,
    output logic [4:0]              o_rd_write_index,
    output logic [XLEN-1:0]         o_rd_write_data,
    output logic [GID_W-1:0]        o_grant_id,
    output logic [31:0]             o_busy_mask
);

    logic [GID_W-1:0] r_rr_ptr;
    logic             r_we;
    logic [4:0]       r_index;
    logic [XLEN-1:0]  r_data;
    logic [GID_W-1:0] r_gid;
    logic [31:0]      r_busy;

    logic             w_found;
    logic [GID_W-1:0] w_winner;
    logic [4:0]       w_win_index;
    logic [XLEN-1:0]  w_win_data;
    logic [N_REQ-1:0] w_ready;
    logic [31:0]      w_busy_next;

    // Pointer to the requester that gets first look after winner w.
    function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] w);
        if (int'(w) >= N_REQ - 1) begin
            return '0;
        end else begin
            return w + GID_W'(1);
        end
    endfunction

    // Round-robin search starting at r_rr_ptr; the register file always accepts the winner.
    always_comb begin
        int v_j;
        w_found     = 1'b0;
        w_winner    = '0;
        w_win_index = 5'd0;
        w_win_data  = '0;
        w_ready     = '0;
        v_j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            v_j = int'(r_rr_ptr) + k;
            if (v_j >= N_REQ) begin
                v_j = v_j - N_REQ;
            end else begin
                v_j = v_j;
            end
            if (!w_found && i_req_valid[v_j]) begin
                w_found     = 1'b1;
                w_winner    = GID_W'(v_j);
                w_win_index = i_req_rd_index[v_j*5 +: 5];
                w_win_data  = i_req_rd_data[v_j*XLEN +: XLEN];
                w_ready[v_j] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Scoreboard next state: clear on write-back, then set on issue so a newer producer wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_found && (w_win_index != 5'd0)) begin
            w_busy_next[w_win_index] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (i_issue_valid && (i_issue_rd_index != 5'd0)) begin
            w_busy_next[i_issue_rd_index] = 1'b1;
        end else begin
            w_busy_next = w_busy_next;
        end
        w_busy_next[0] = 1'b0;
    end

    // Output stage, round-robin pointer and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_index  <= 5'd0;
            r_data   <= '0;
            r_gid    <= '0;
            r_busy   <= 32'd0;
        end else begin
            r_we   <= w_found && (w_win_index != 5'd0);
            r_busy <= w_busy_next;
            if (w_found) begin
                r_index  <= w_win_index;
                r_data   <= w_win_data;
                r_gid    <= w_winner;
                r_rr_ptr <= next_ptr(w_winner);
            end
        end
    end

    assign o_req_ready       = w_ready;
    assign o_rd_write_enable = r_we;
    assign o_rd_write_index  = r_index;
    assign o_rd_write_data   = r_data;
    assign o_grant_id        = r_gid;
    assign o_busy_mask       = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N     = 3;
    localparam int XLEN  = 32;
    localparam int GID_W = 2;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       i_req_valid;
    logic [N-1:0]       o_req_ready;
    logic [N*5-1:0]     i_req_rd_index;
    logic [N*XLEN-1:0]  i_req_rd_data;
    logic               i_issue_valid;
    logic [4:0]         i_issue_rd_index;
    logic               o_rd_write_enable;
    logic [4:0]         o_rd_write_index;
    logic [XLEN-1:0]    o_rd_write_data;
    logic [GID_W-1:0]   o_grant_id;
    logic [31:0]        o_busy_mask;

    regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_rd_index    (i_req_rd_index),
        .i_req_rd_data     (i_req_rd_data),
        .i_issue_valid     (i_issue_valid),
        .i_issue_rd_index  (i_issue_rd_index),
        .o_rd_write_enable (o_rd_write_enable),
        .o_rd_write_index  (o_rd_write_index),
        .o_rd_write_data   (o_rd_write_data),
        .o_grant_id        (o_grant_id),
        .o_busy_mask       (o_busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus requested for the coming cycle.
    logic [N-1:0]     d_valid;
    logic [4:0]       d_idx [N];
    logic [XLEN-1:0]  d_data [N];
    logic             d_issue;
    logic [4:0]       d_iidx;

    // Behavioural model state.
    int               m_ptr;
    logic [31:0]      m_busy;
    logic             exp_we;
    logic [4:0]       exp_idx;
    logic [XLEN-1:0]  exp_data;
    logic [GID_W-1:0] exp_gid;
    logic [N-1:0]     exp_ready;
    int               last_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_busy   = 32'd0;
        exp_we   = 1'b0;
        exp_idx  = 5'd0;
        exp_data = '0;
        exp_gid  = '0;
        last_w   = -1;
    endtask

    task automatic clear_drive();
        d_valid = '0;
        d_issue = 1'b0;
        d_iidx  = 5'd0;
        for (int i = 0; i < N; i++) begin
            d_idx[i]  = 5'd0;
            d_data[i] = '0;
        end
    endtask

    task automatic apply_drive();
        i_req_valid      = d_valid;
        i_issue_valid    = d_issue;
        i_issue_rd_index = d_iidx;
        for (int i = 0; i < N; i++) begin
            i_req_rd_index[i*5 +: 5]       = d_idx[i];
            i_req_rd_data[i*XLEN +: XLEN]  = d_data[i];
        end
    endtask

    // One clock: check registered outputs, drive, check ready, advance model.
    task automatic step();
        int w;
        logic [31:0] nb;
        @(posedge clk);
        #1;
        chk("we",   {63'd0, o_rd_write_enable}, {63'd0, exp_we});
        chk("idx",  {59'd0, o_rd_write_index},  {59'd0, exp_idx});
        chk("data", {32'd0, o_rd_write_data},   {32'd0, exp_data});
        chk("gid",  {62'd0, o_grant_id},        {62'd0, exp_gid});
        chk("busy", {32'd0, o_busy_mask},       {32'd0, m_busy});
        apply_drive();
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && d_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("ready", {61'd0, o_req_ready}, {61'd0, exp_ready});
        nb = m_busy;
        if (w >= 0) begin
            exp_idx  = d_idx[w];
            exp_data = d_data[w];
            exp_gid  = GID_W'(w);
            exp_we   = (d_idx[w] != 5'd0);
            m_ptr    = (w + 1) % N;
            if (d_idx[w] != 5'd0) nb[d_idx[w]] = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (d_issue && d_iidx != 5'd0) nb[d_iidx] = 1'b1;
        m_busy = nb;
        last_w = w;
    endtask

    task automatic do_reset();
        clear_drive();
        apply_drive();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_drive();
        apply_drive();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_we",   {63'd0, o_rd_write_enable}, 64'd0);
        chk("rst_busy", {32'd0, o_busy_mask}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All requesters continuously valid: grants rotate 0,1,2,0,1.
        for (int s = 0; s < 5; s++) begin
            d_valid = 3'b111;
            for (int i = 0; i < N; i++) begin
                d_idx[i]  = 5'(i + 1);
                d_data[i] = 32'(s * 16 + i);
            end
            step();
            chk("rot_ready", {61'd0, o_req_ready}, 64'd1 << (s % 3));
            if (s > 0) chk("rot_we", {63'd0, o_rd_write_enable}, 64'd1);
        end

        // Single requester 1 writes x5.
        do_reset();
        d_valid = 3'b010; d_idx[1] = 5'd5; d_data[1] = 32'hDEADBEEF;
        step();
        chk("t1_ready", {61'd0, o_req_ready}, 64'h2);
        clear_drive();
        step();
        chk("t1_we",   {63'd0, o_rd_write_enable}, 64'd1);
        chk("t1_idx",  {59'd0, o_rd_write_index},  64'd5);
        chk("t1_data", {32'd0, o_rd_write_data},   64'hDEADBEEF);
        chk("t1_gid",  {62'd0, o_grant_id},        64'd1);
        step();
        chk("t1_we_off", {63'd0, o_rd_write_enable}, 64'd0);

        // Pointer now at 2: req 2 beats req 0, then req 0 wins.
        d_valid = 3'b101; d_idx[0] = 5'd3; d_idx[2] = 5'd4;
        step();
        chk("t3_ready2", {61'd0, o_req_ready}, 64'h4);
        d_valid = 3'b001;
        step();
        chk("t3_ready0", {61'd0, o_req_ready}, 64'h1);

        // Write to x0 is accepted without a write enable.
        d_valid = 3'b001; d_idx[0] = 5'd0; d_data[0] = 32'h1234;
        step();
        chk("t4_ready", {61'd0, o_req_ready}, 64'h1);
        clear_drive();
        step();
        chk("t4_we", {63'd0, o_rd_write_enable}, 64'd0);

        // Scoreboard set/clear and set-wins collision on x7.
        do_reset();
        d_issue = 1'b1; d_iidx = 5'd7;
        step();
        clear_drive();
        step();
        chk("t5_set", {32'd0, o_busy_mask}, 64'h80);
        d_valid = 3'b010; d_idx[1] = 5'd7;
        step();
        clear_drive();
        step();
        chk("t5_clr", {32'd0, o_busy_mask}, 64'h0);
        d_issue = 1'b1; d_iidx = 5'd7;
        step();
        d_valid = 3'b100; d_idx[2] = 5'd7;
        step();
        clear_drive();
        step();
        chk("t5_setwins", {32'd0, o_busy_mask}, 64'h80);
        d_valid = 3'b001; d_idx[0] = 5'd7;
        step();
        clear_drive();
        d_issue = 1'b1; d_iidx = 5'd0;
        step();
        clear_drive();
        step();
        chk("t5_x0", {32'd0, o_busy_mask}, 64'h0);

        // Randomised traffic with held requests and random issues.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!d_valid[i] && ($urandom % 3 == 0)) begin
                    d_valid[i] = 1'b1;
                    d_idx[i]   = 5'($urandom % 32);
                    d_data[i]  = $urandom;
                end
            end
            d_issue = ($urandom % 2 == 0);
            d_iidx  = 5'($urandom % 32);
            step();
            if (last_w >= 0) d_valid[last_w] = 1'b0;
        end

        // Mid-cycle reset with busy x5/x7 and requests in flight.
        do_reset();
        d_issue = 1'b1; d_iidx = 5'd5;
        step();
        d_iidx = 5'd7;
        step();
        d_issue = 1'b0;
        d_valid = 3'b111; d_idx[0] = 5'd1; d_idx[1] = 5'd2; d_idx[2] = 5'd3;
        step();
        chk("t6_busy", {32'd0, o_busy_mask}, 64'hA0);
        d_valid = 3'b110;
        step();
        #2;
        rst_n = 1'b0;
        clear_drive();
        apply_drive();
        #1;
        chk("t6_we",    {63'd0, o_rd_write_enable}, 64'd0);
        chk("t6_idx",   {59'd0, o_rd_write_index},  64'd0);
        chk("t6_data",  {32'd0, o_rd_write_data},   64'd0);
        chk("t6_gid",   {62'd0, o_grant_id},        64'd0);
        chk("t6_busy0", {32'd0, o_busy_mask},       64'd0);
        chk("t6_ready", {61'd0, o_req_ready},       64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 3'b101; d_idx[0] = 5'd9; d_idx[2] = 5'd10;
        step();
        chk("t6_first", {61'd0, o_req_ready}, 64'h1);
        clear_drive();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
